// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (CPU, loader) and the DMem RAM.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              c_req;
  logic              c_we;
  logic [1:0]        c_size;
  logic              c_uns;
  logic [31:0]       c_addr;
  logic [31:0]       c_wdata;
  logic              c_ack;
  logic              c_err;
  logic [31:0]       c_rdata;

  logic              l_req;
  logic              l_we;
  logic [31:0]       l_addr;
  logic [31:0]       l_wdata;
  logic              l_ack;
  logic [31:0]       l_rdata;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  modport slave (
    input  c_req, c_we, c_size, c_uns, c_addr, c_wdata,
    output c_ack, c_err, c_rdata,
    input  l_req, l_we, l_addr, l_wdata,
    output l_ack, l_rdata,
    output ram_we, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output c_req, c_we, c_size, c_uns, c_addr, c_wdata,
    input  c_ack, c_err, c_rdata,
    output l_req, l_we, l_addr, l_wdata,
    input  l_ack, l_rdata,
    input  ram_we, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port synchronous DMem RAM between the CPU load/store port and the UART loader,
// doing read-modify-write for byte/half stores and extension for sub-word loads.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 14,
  parameter bit          PRIO_MODE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, RDW, WR, ACK} state_e;

  state_e            state_q;
  logic              owner_q;   // 1 = loader owns the current transaction
  logic              rr_q;      // 1 = loader preferred on next contention
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [15:0]       wdata_q;
  logic [31:0]       din_q;
  logic [31:0]       c_rdata_q;
  logic [31:0]       l_rdata_q;
  logic              c_ack_q;
  logic              l_ack_q;
  logic              c_err_q;

  logic              grant_l_d;
  logic              c_mis_d;
  logic [7:0]        byte_d;
  logic [15:0]       half_d;
  logic [31:0]       ext_d;
  logic [31:0]       merge_d;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{bus.c_addr[31:ADDR_W+2], bus.l_addr[31:ADDR_W+2], bus.l_addr[1:0]};

  always_comb begin
    grant_l_d = bus.l_req;
    if (bus.c_req && bus.l_req) begin
      if (PRIO_MODE) grant_l_d = 1'b0;
      else           grant_l_d = rr_q;
    end
  end

  always_comb begin
    c_mis_d = 1'b0;
    case (bus.c_size)
      2'b00:   c_mis_d = 1'b0;
      2'b01:   c_mis_d = bus.c_addr[0];
      2'b10:   c_mis_d = (bus.c_addr[1:0] != 2'b00);
      default: c_mis_d = 1'b1;
    endcase
  end

  always_comb begin
    byte_d = bus.ram_dout[{lane_q, 3'b000} +: 8];
    half_d = lane_q[1] ? bus.ram_dout[31:16] : bus.ram_dout[15:0];
    ext_d  = bus.ram_dout;
    case (size_q)
      2'b00:   ext_d = {{24{~uns_q & byte_d[7]}}, byte_d};
      2'b01:   ext_d = {{16{~uns_q & half_d[15]}}, half_d};
      default: ext_d = bus.ram_dout;
    endcase
  end

  // Only sub-word C stores reach the merge, so size is 00 or 01 here.
  always_comb begin
    merge_d = bus.ram_dout;
    if (size_q == 2'b00)  merge_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else if (lane_q[1])   merge_d[31:16] = wdata_q;
    else                  merge_d[15:0]  = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= '0;
      lane_q    <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      din_q     <= '0;
      c_rdata_q <= '0;
      l_rdata_q <= '0;
      c_ack_q   <= 1'b0;
      l_ack_q   <= 1'b0;
      c_err_q   <= 1'b0;
    end else begin
      c_ack_q <= 1'b0;
      l_ack_q <= 1'b0;
      c_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.c_req || bus.l_req) begin
            owner_q <= grant_l_d;
            if (!PRIO_MODE) rr_q <= ~grant_l_d;
            if (grant_l_d) begin
              we_q    <= bus.l_we;
              uns_q   <= 1'b0;
              size_q  <= 2'b10;
              lane_q  <= 2'b00;
              waddr_q <= bus.l_addr[ADDR_W+1:2];
              din_q   <= bus.l_wdata;
              state_q <= bus.l_we ? WR : RD;
            end else begin
              we_q    <= bus.c_we;
              uns_q   <= bus.c_uns;
              size_q  <= bus.c_size;
              lane_q  <= bus.c_addr[1:0];
              waddr_q <= bus.c_addr[ADDR_W+1:2];
              wdata_q <= bus.c_wdata[15:0];
              if (c_mis_d) begin
                c_ack_q <= 1'b1;
                c_err_q <= 1'b1;
                state_q <= ACK;
              end else if (bus.c_we && bus.c_size == 2'b10) begin
                din_q   <= bus.c_wdata;
                state_q <= WR;
              end else begin
                state_q <= RD;
              end
            end
          end
        end
        RD: state_q <= RDW;
        RDW: begin
          if (we_q) begin
            din_q   <= merge_d;
            state_q <= WR;
          end else begin
            if (owner_q) begin
              l_rdata_q <= bus.ram_dout;
              l_ack_q   <= 1'b1;
            end else begin
              c_rdata_q <= ext_d;
              c_ack_q   <= 1'b1;
            end
            state_q <= ACK;
          end
        end
        WR: begin
          if (owner_q) l_ack_q <= 1'b1;
          else         c_ack_q <= 1'b1;
          state_q <= ACK;
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.c_ack    = c_ack_q;
  assign bus.c_err    = c_err_q;
  assign bus.c_rdata  = c_rdata_q;
  assign bus.l_ack    = l_ack_q;
  assign bus.l_rdata  = l_rdata_q;
  assign bus.ram_we   = (state_q == WR);
  assign bus.ram_addr = waddr_q;
  assign bus.ram_din  = din_q;

endmodule
